// File: rtl/id_regfile_sb_pkg.sv
// id_regfile_sb_pkg
// Shared constants for the ID-stage register file and its scoreboard.
//   XLEN     : register data width
//   AW       : register address width
//   NREGS    : number of architectural registers (2**AW)
//   ZERO_REG : hard-wired zero register index
package id_regfile_sb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/id_regfile_sb_board.sv
// regfile_sb_board
// Pending-write scoreboard: one busy bit per register, set when an
// instruction that writes it issues, cleared when its write-back lands.
// Also performs the per-port RAW hazard lookup.
// Ports:
//   clk, rst                   : clock, async active-high reset
//   wb_we, wb_waddr            : write-back (clears busy)
//   issue_we, issue_waddr      : issue (sets busy)
//   flush                      : clears every busy bit, drops same-cycle issue
//   raddr1/re1, raddr2/re2     : read ports to check for hazards
//   stall                      : OR of both ports' hazards
//   busy                       : scoreboard vector
module regfile_sb_board #(
    parameter int unsigned AW    = 5,
    parameter int unsigned NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_waddr,
    input  logic             issue_we,
    input  logic [AW-1:0]    issue_waddr,
    input  logic             flush,
    input  logic [AW-1:0]    raddr1,
    input  logic             re1,
    input  logic [AW-1:0]    raddr2,
    input  logic             re2,
    output logic             stall,
    output logic [NREGS-1:0] busy
);
    import id_regfile_sb_pkg::*;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic             hazard1;
    logic             hazard2;

    // Clear before set, so an issue and write-back to the same register in
    // one cycle leaves it busy (the newer instruction owns it).
    always_comb begin
        busy_nxt = busy_q;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wb_we)    busy_nxt[wb_waddr]    = 1'b0;
            if (issue_we) busy_nxt[issue_waddr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_nxt;
    end

    // A same-cycle write-back to the read address is bypassed, so it
    // resolves the hazard instead of causing one.
    always_comb begin
        hazard1 = re1 && (raddr1 != ZERO_REG) && busy_q[raddr1]
                  && !(wb_we && (wb_waddr == raddr1));
        hazard2 = re2 && (raddr2 != ZERO_REG) && busy_q[raddr2]
                  && !(wb_we && (wb_waddr == raddr2));
        stall   = hazard1 || hazard2;
    end

    assign busy = busy_q;

endmodule

// File: rtl/id_regfile_sb.sv
// id_regfile_sb
// Register-file responder for the decoder's two read ports. Holds the 32
// integer registers (x0 hard-wired to zero), serves both ports
// combinationally with write-back bypass, and raises stall_o on RAW hazards
// via the pending-write scoreboard.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   reg1_raddr_i/re_i/rdata_o     : read port 1
//   reg2_raddr_i/re_i/rdata_o     : read port 2
//   wb_we_i, wb_waddr_i, wb_wdata_i : write-back
//   issue_we_i, issue_waddr_i     : destination of instruction leaving ID
//   flush_i                       : clears all pending marks
//   stall_o                       : RAW hazard, ID must hold
//   busy_o                        : scoreboard vector (debug)
module id_regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    reg1_raddr_i,
    input  logic             reg1_re_i,
    output logic [XLEN-1:0]  reg1_rdata_o,
    input  logic [AW-1:0]    reg2_raddr_i,
    input  logic             reg2_re_i,
    output logic [XLEN-1:0]  reg2_rdata_o,
    input  logic             wb_we_i,
    input  logic [AW-1:0]    wb_waddr_i,
    input  logic [XLEN-1:0]  wb_wdata_i,
    input  logic             issue_we_i,
    input  logic [AW-1:0]    issue_waddr_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [NREGS-1:0] busy_o
);
    import id_regfile_sb_pkg::*;

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we_i && (wb_waddr_i != ZERO_REG)) begin
            regs[wb_waddr_i] <= wb_wdata_i;
        end
    end

    function automatic logic [XLEN-1:0] read_mux(
        input logic            re,
        input logic [AW-1:0]   raddr,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata
    );
        if (!re || (raddr == ZERO_REG)) return '0;
        if (we && (waddr == raddr))     return wdata;
        return stored;
    endfunction

    // Gated by rst so a write-back presented during reset cannot leak
    // through the bypass path.
    always_comb begin
        reg1_rdata_o = '0;
        reg2_rdata_o = '0;
        if (!rst) begin
            reg1_rdata_o = read_mux(reg1_re_i, reg1_raddr_i, regs[reg1_raddr_i],
                                    wb_we_i, wb_waddr_i, wb_wdata_i);
            reg2_rdata_o = read_mux(reg2_re_i, reg2_raddr_i, regs[reg2_raddr_i],
                                    wb_we_i, wb_waddr_i, wb_wdata_i);
        end
    end

    regfile_sb_board #(
        .AW    (AW),
        .NREGS (NREGS)
    ) u_board (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we_i),
        .wb_waddr    (wb_waddr_i),
        .issue_we    (issue_we_i),
        .issue_waddr (issue_waddr_i),
        .flush       (flush_i),
        .raddr1      (reg1_raddr_i),
        .re1         (reg1_re_i),
        .raddr2      (reg2_raddr_i),
        .re2         (reg2_re_i),
        .stall       (stall_o),
        .busy        (busy_o)
    );

endmodule

// File: tb/tb_id_regfile_sb.sv
module tb_id_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg1_raddr, reg2_raddr, wb_waddr, issue_waddr;
    logic        reg1_re, reg2_re, wb_we, issue_we, flush;
    logic [31:0] reg1_rdata, reg2_rdata, wb_wdata, busy;
    logic        stall;

    id_regfile_sb #(.XLEN(32), .AW(5), .NREGS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .reg1_raddr_i  (reg1_raddr),
        .reg1_re_i     (reg1_re),
        .reg1_rdata_o  (reg1_rdata),
        .reg2_raddr_i  (reg2_raddr),
        .reg2_re_i     (reg2_re),
        .reg2_rdata_o  (reg2_rdata),
        .wb_we_i       (wb_we),
        .wb_waddr_i    (wb_waddr),
        .wb_wdata_i    (wb_wdata),
        .issue_we_i    (issue_we),
        .issue_waddr_i (issue_waddr),
        .flush_i       (flush),
        .stall_o       (stall),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        re1;  bit [4:0] a1;
        bit        re2;  bit [4:0] a2;
        bit        wbwe; bit [4:0] wba; bit [31:0] wbd;
        bit        iswe; bit [4:0] isa;
        bit        fl;
        bit [31:0] e_r1; bit [31:0] e_r2; bit e_st; bit [31:0] e_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents and pending set.
    bit [31:0] m_regs [32];
    bit        m_busy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit [31:0] m_read(bit re, bit [4:0] a);
        if (!re || a == 0) return 32'h0;
        if (wb_we && wb_waddr == a) return wb_wdata;
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        bit s = 1'b0;
        if (reg1_re && reg1_raddr != 0 && m_busy[reg1_raddr] && !(wb_we && wb_waddr == reg1_raddr)) s = 1'b1;
        if (reg2_re && reg2_raddr != 0 && m_busy[reg2_raddr] && !(wb_we && wb_waddr == reg2_raddr)) s = 1'b1;
        return s;
    endfunction

    function automatic bit [31:0] m_busy_vec();
        bit [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clock();
        if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (wb_we) m_busy[wb_waddr] = 1'b0;
            if (issue_we && issue_waddr != 0) m_busy[issue_waddr] = 1'b1;
        end
    endtask

    task automatic drive(input vec_t v);
        reg1_re = v.re1;   reg1_raddr = v.a1;
        reg2_re = v.re2;   reg2_raddr = v.a2;
        wb_we = v.wbwe;    wb_waddr = v.wba;   wb_wdata = v.wbd;
        issue_we = v.iswe; issue_waddr = v.isa;
        flush = v.fl;
    endtask

    task automatic idle();
        vec_t z = '{default: 0};
        drive(z);
    endtask

    vec_t tbl [15];

    initial begin
        // re1 a1 re2 a2 wbwe wba wbd iswe isa fl | r1 r2 stall busy_after
        tbl[0]  = '{1, 5, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 3, 1, 0, 1, 0, 32'h12345678, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0};
        tbl[3]  = '{1, 3, 1, 7, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,            1, 10, 0, 0, 0, 0, 32'h400};
        tbl[5]  = '{1, 10, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 1, 32'h400};
        tbl[6]  = '{1, 10, 0, 0, 1, 10, 32'h55,     0, 0, 0, 32'h55, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 4, 32'h44,       1, 4, 0, 0, 0, 0, 32'h10};
        tbl[8]  = '{1, 4, 0, 4, 0, 0, 0,            1, 6, 1, 32'h44, 0, 1, 0};
        tbl[9]  = '{1, 6, 1, 4, 0, 0, 0,            0, 0, 0, 0, 32'h44, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0,            1, 31, 0, 0, 0, 0, 32'h80000000};
        tbl[12] = '{0, 0, 1, 31, 1, 31, 32'hCAFEF00D, 1, 1, 0, 0, 32'hCAFEF00D, 0, 32'h2};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0,            0, 0, 0, 0, 0, 1, 32'h2};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0};
    end

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #12;
        chk("reset_busy", busy, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_r1", i), reg1_rdata, tbl[i].e_r1);
            chk($sformatf("tbl%0d_r2", i), reg2_rdata, tbl[i].e_r2);
            chk($sformatf("tbl%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_st});
            @(posedge clk);
            model_clock();
            #1;
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end

        // Async reset mid-cycle with x3 holding data and x10 pending
        @(negedge clk);
        idle();
        issue_we = 1'b1; issue_waddr = 5'd10;
        @(posedge clk);
        model_clock();
        #1;
        chk("arst_pre_busy", busy, 32'h400);
        idle();
        reg1_re = 1'b1; reg1_raddr = 5'd3;
        #1;
        chk("arst_pre_x3", reg1_rdata, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 32'h0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_x3", reg1_rdata, 32'h0);
        chk("arst_busy_after", busy, 32'h0);

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reg1_re     = ($urandom_range(0, 3) != 0);
            reg1_raddr  = 5'($urandom_range(0, 7));
            reg2_re     = ($urandom_range(0, 3) != 0);
            reg2_raddr  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_we       = ($urandom_range(0, 1) == 1);
            wb_waddr    = 5'($urandom_range(0, 7));
            wb_wdata    = $urandom;
            issue_we    = ($urandom_range(0, 2) != 0);
            issue_waddr = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 19) == 0);
            #1;
            chk("rnd_r1", reg1_rdata, m_read(reg1_re, reg1_raddr));
            chk("rnd_r2", reg2_rdata, m_read(reg2_re, reg2_raddr));
            chk("rnd_stall", {31'b0, stall}, {31'b0, m_stall()});
            @(posedge clk);
            model_clock();
            #1;
            chk("rnd_busy", busy, m_busy_vec());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- Register-file responder at the far end of the decoder's read-port interface (regN_raddr / regN_re -> regN_rdata).
- Holds the 32 architectural integer registers and serves two combinational read ports with write-back bypass.
- Keeps a per-register pending-write scoreboard, set on issue and cleared on write-back, and raises stall_o to the ID stage on a RAW hazard.
- Sits between the ID decoders and the EX/WB pipeline.

Parameters:
- XLEN, 32, register data width (matches RDATA_WIDTH).
- AW, 5, register address width (matches RADDR_WIDTH).
- NREGS, 32, number of registers; must equal 2**AW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reg1_raddr_i  in  AW  read port 1 address (from decoder reg1_raddr_o).
- reg1_re_i  in  1  read port 1 enable.
- reg1_rdata_o  out  XLEN  read port 1 data.
- reg2_raddr_i  in  AW  read port 2 address.
- reg2_re_i  in  1  read port 2 enable.
- reg2_rdata_o  out  XLEN  read port 2 data.
- wb_we_i  in  1  write-back enable.
- wb_waddr_i  in  AW  write-back address.
- wb_wdata_i  in  XLEN  write-back data.
- issue_we_i  in  1  instruction leaving ID will write a register.
- issue_waddr_i  in  AW  destination of the issuing instruction.
- flush_i  in  1  pipeline flush; clears all pending marks.
- stall_o  out  1  RAW hazard; ID must hold.
- busy_o  out  NREGS  scoreboard vector, for debug and verification.

Behaviour:
- Clock and reset are fixed: one clock (clk); rst is asynchronous, active-high.
- Reset:
  - all registers = 0, busy = 0.
  - reg*_rdata_o and stall_o are driven combinationally, so they evaluate to 0 during reset.
- Write:
  - On posedge clk, if wb_we_i=1 and wb_waddr_i!=0, then regs[wb_waddr_i] <= wb_wdata_i.
  - A write to x0 is ignored; x0 always reads 0.
- Read (combinational, 0-cycle latency), per port:
  - re=0 -> rdata=0.
  - raddr=0 -> rdata=0.
  - re=1, wb_we_i=1, wb_waddr_i==raddr, raddr!=0 -> rdata=wb_wdata_i (same-cycle bypass).
  - otherwise rdata=regs[raddr].
- Scoreboard, updated on posedge clk, in priority order:
  1. flush_i=1 -> busy <= 0. Issue in the same cycle is ignored. Write-back still updates the register array.
  2. Otherwise, wb_we_i clears busy[wb_waddr_i], and issue_we_i sets busy[issue_waddr_i].
  3. Same address for issue and wb in one cycle -> busy stays 1 (the new issue wins).
  4. Index 0 is never set; busy[0] is constant 0.
- stall_o is combinational and asserts when either port has re=1, raddr!=0, busy[raddr]=1, and no same-cycle write-back to raddr.
  - A write-back to raddr in the same cycle bypasses the value and suppresses the stall.
- Register both ports' hazard checks independently and OR them into stall_o.
- Reset asserted mid-operation clears the register array and busy immediately, without waiting for a clock edge.
- Issue while stall_o=1 is the upstream's responsibility; the block still obeys issue_we_i.
- Widths: no arithmetic. Addresses are used unsigned. Data passes bit-exact.

Decomposition:
- Add to the shared defines file: XLEN, AW, NREGS, and a ZERO_REG constant (5'd0).
- Add one sub-module, regfile_sb_board: the busy-vector flops, the set/clear/flush logic, and per-port hazard lookup.
- Keep the register array and bypass muxes in the top module.

Test Plan:
1. Reset then read:
   - Stimulus: assert rst, release; read x5 with re=1.
   - Required: rdata=0x00000000, stall_o=0, busy_o=0.
2. Write/read and x0:
   - Stimulus: wb x3=0xDEADBEEF; next cycle read x3 on port 1. Separately, wb x0=0x12345678 and read x0.
   - Required: port 1 returns 0xDEADBEEF; x0 reads 0.
3. Bypass:
   - Stimulus: in the same cycle, wb x7=0xA5A5A5A5 and read x7 on port 2.
   - Required: reg2_rdata_o=0xA5A5A5A5 with no clock edge.
4. RAW stall:
   - Stimulus: issue x10; next cycle read x10 (re=1).
   - Required: stall_o=1 and busy_o[10]=1.
   - Then: wb x10=0x55 -> stall_o=0 that cycle and rdata=0x55; busy_o[10]=0 after the edge.
5. Collision and flush:
   - Stimulus: issue x4 and wb x4 in the same cycle.
   - Required: busy_o[4]=1.
   - Then: flush_i=1 with issue x6 -> busy_o=0 next cycle.
6. Async reset mid-run:
   - Stimulus: with x3=0xDEADBEEF and busy[10]=1, pulse rst between clock edges.
   - Required: x3 reads 0 and busy_o=0 before the next posedge.
